// File: rtl/m_pipeline_stage4_mem_if.sv
// EX/MEM -> MEM/WB bundle for the memory stage of the 5-stage MIPS pipeline.
// The master drives the EX/MEM side and control; the slave (the stage) drives the WB side.
interface m_pipeline_stage4_mem_if #(
    parameter int N     = 32,
    parameter int N_REG = 256
);
    localparam int RW = $clog2(N_REG);

    logic          stall;
    logic          flush;
    logic          valid_in;
    logic          mem_read_in;
    logic          mem_write_in;
    logic          mem_to_reg_in;
    logic          reg_write_in;
    logic [N-1:0]  alu_out_in;
    logic [N-1:0]  store_data_in;
    logic [RW-1:0] write_reg_in;

    logic          mem_to_reg;
    logic [N-1:0]  read_data;
    logic [N-1:0]  alu_out;
    logic          reg_write;
    logic [RW-1:0] write_reg;
    logic          misalign_err;
    logic [7:0]    err_count;

    modport master (
        output stall, flush, valid_in, mem_read_in, mem_write_in, mem_to_reg_in,
               reg_write_in, alu_out_in, store_data_in, write_reg_in,
        input  mem_to_reg, read_data, alu_out, reg_write, write_reg,
               misalign_err, err_count
    );

    modport slave (
        input  stall, flush, valid_in, mem_read_in, mem_write_in, mem_to_reg_in,
               reg_write_in, alu_out_in, store_data_in, write_reg_in,
        output mem_to_reg, read_data, alu_out, reg_write, write_reg,
               misalign_err, err_count
    );
endinterface

// File: rtl/m_pipeline_stage4_mem.sv
// MIPS pipeline stage 4: word loads/stores against an internal data memory,
// alignment checking, and the MEM/WB pipeline register feeding write-back.
module m_pipeline_stage4_mem #(
    parameter int N         = 32,
    parameter int N_REG     = 256,
    parameter int MEM_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    m_pipeline_stage4_mem_if.slave bus
);
    localparam int IW = $clog2(MEM_WORDS);

    logic [N-1:0]  mem [MEM_WORDS];
    logic [IW-1:0] index;
    logic          access;
    logic          misaligned;
    logic          do_store;

    assign index      = bus.alu_out_in[IW+1:2];
    assign access     = bus.valid_in & (bus.mem_read_in | bus.mem_write_in);
    assign misaligned = access & (bus.alu_out_in[1:0] != 2'b00);
    assign do_store   = reset & bus.valid_in & bus.mem_write_in & ~misaligned
                      & ~bus.stall & ~bus.flush;

    // Memory contents survive reset; only the write enable is gated by it.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[index] <= bus.store_data_in;
        end
    end

    // MEM/WB register: flush beats stall, stall beats everything else.
    // read_data samples mem before this edge's store lands (read-before-write).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_to_reg   <= 1'b0;
            bus.read_data    <= '0;
            bus.alu_out      <= '0;
            bus.reg_write    <= 1'b0;
            bus.write_reg    <= '0;
            bus.misalign_err <= 1'b0;
            bus.err_count    <= 8'd0;
        end else if (bus.flush || (!bus.stall && !bus.valid_in)) begin
            bus.mem_to_reg   <= 1'b0;
            bus.read_data    <= '0;
            bus.alu_out      <= '0;
            bus.reg_write    <= 1'b0;
            bus.write_reg    <= '0;
            bus.misalign_err <= 1'b0;
        end else if (bus.stall) begin
            bus.mem_to_reg   <= bus.mem_to_reg;
        end else if (misaligned) begin
            bus.mem_to_reg   <= 1'b0;
            bus.read_data    <= '0;
            bus.alu_out      <= bus.alu_out_in;
            bus.reg_write    <= 1'b0;
            bus.write_reg    <= bus.write_reg_in;
            bus.misalign_err <= 1'b1;
            if (bus.err_count != 8'hFF) begin
                bus.err_count <= bus.err_count + 8'd1;
            end
        end else begin
            bus.mem_to_reg   <= bus.mem_to_reg_in;
            bus.read_data    <= bus.mem_read_in ? mem[index] : '0;
            bus.alu_out      <= bus.alu_out_in;
            bus.reg_write    <= bus.reg_write_in;
            bus.write_reg    <= bus.write_reg_in;
            bus.misalign_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_m_pipeline_stage4_mem.sv
// Scoreboard bench for m_pipeline_stage4_mem: directed vectors push hand-computed
// WB bundles; a monitor pops one per edge and compares.
module tb_m_pipeline_stage4_mem;
    logic clk;
    logic reset;

    m_pipeline_stage4_mem_if #(.N(32), .N_REG(256)) bus ();

    m_pipeline_stage4_mem #(.N(32), .N_REG(256), .MEM_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        stall, flush, valid, rd, wr, m2r, rw;
        logic [31:0] addr, data;
        logic [7:0]  wreg;
    } vec_t;

    typedef struct packed {
        logic        m2r;
        logic [31:0] rdata, aout;
        logic        rw;
        logic [7:0]  wreg;
        logic        merr;
        logic [7:0]  ecnt;
    } exp_t;

    exp_t scoreboard[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t st(input logic [31:0] a, input logic [31:0] d);
        return '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a, d, 8'd0};
    endfunction

    function automatic vec_t ld(input logic [31:0] a, input logic [7:0] w);
        return '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, a, 32'h0, w};
    endfunction

    function automatic vec_t alu(input logic [31:0] a, input logic [7:0] w);
        return '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a, 32'h0, w};
    endfunction

    function automatic exp_t ex(input logic m2r, input logic [31:0] rdata,
                                input logic [31:0] aout, input logic rw,
                                input logic [7:0] wreg, input logic merr,
                                input logic [7:0] ecnt);
        return '{m2r, rdata, aout, rw, wreg, merr, ecnt};
    endfunction

    task automatic drive(input vec_t v);
        bus.stall         = v.stall;
        bus.flush         = v.flush;
        bus.valid_in      = v.valid;
        bus.mem_read_in   = v.rd;
        bus.mem_write_in  = v.wr;
        bus.mem_to_reg_in = v.m2r;
        bus.reg_write_in  = v.rw;
        bus.alu_out_in    = v.addr;
        bus.store_data_in = v.data;
        bus.write_reg_in  = v.wreg;
    endtask

    task automatic applyStimulus(input vec_t v, input exp_t e);
        @(negedge clk);
        drive(v);
        scoreboard.push_back(e);
    endtask

    function automatic exp_t sampleDut();
        return '{bus.mem_to_reg, bus.read_data, bus.alu_out, bus.reg_write,
                 bus.write_reg, bus.misalign_err, bus.err_count};
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        exp_t a;
        a = sampleDut();
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s step=%0d got m2r=%0b rd=%h ao=%h rw=%0b wr=%0d merr=%0b ecnt=%0d want m2r=%0b rd=%h ao=%h rw=%0b wr=%0d merr=%0b ecnt=%0d",
                     name, step, a.m2r, a.rdata, a.aout, a.rw, a.wreg, a.merr, a.ecnt,
                     e.m2r, e.rdata, e.aout, e.rw, e.wreg, e.merr, e.ecnt);
        end
    endtask

    // Monitor: the WB bundle is presented after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() > 0) begin
                step++;
                checkOutput("wb_bundle", scoreboard.pop_front());
            end
        end
    end

    initial begin
        vec_t v;
        exp_t hold_a;

        drive('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'd0});
        reset = 1'b0;
        #12;
        checkOutput("reset_state", ex(0, 32'h0, 32'h0, 0, 8'd0, 0, 8'd0));
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(st(32'h40, 32'hDEADBEEF), ex(0, 32'h0, 32'h40, 0, 8'd0, 0, 8'd0));
        applyStimulus(ld(32'h40, 8'd9), ex(1, 32'hDEADBEEF, 32'h40, 1, 8'd9, 0, 8'd0));
        applyStimulus(ld(32'h42, 8'd3), ex(0, 32'h0, 32'h42, 0, 8'd3, 1, 8'd1));
        applyStimulus(st(32'h80, 32'h11111111), ex(0, 32'h0, 32'h80, 0, 8'd0, 0, 8'd1));

        hold_a = ex(0, 32'h0, 32'h1234, 1, 8'd5, 0, 8'd1);
        applyStimulus(alu(32'h1234, 8'd5), hold_a);
        v = st(32'h80, 32'h22222222);
        v.stall = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(v, hold_a);
        applyStimulus(st(32'h80, 32'h22222222), ex(0, 32'h0, 32'h80, 0, 8'd0, 0, 8'd1));

        applyStimulus(alu(32'h1234, 8'd5), hold_a);
        v = st(32'h80, 32'h33333333);
        v.stall = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(v, hold_a);
        applyStimulus(ld(32'h80, 8'd7), ex(1, 32'h22222222, 32'h80, 1, 8'd7, 0, 8'd1));

        v = st(32'h80, 32'h99999999);
        v.stall = 1'b1;
        v.flush = 1'b1;
        v.rw    = 1'b1;
        applyStimulus(v, ex(0, 32'h0, 32'h0, 0, 8'd0, 0, 8'd1));
        applyStimulus(ld(32'h80, 8'd7), ex(1, 32'h22222222, 32'h80, 1, 8'd7, 0, 8'd1));

        applyStimulus(st(32'h400, 32'h5), ex(0, 32'h0, 32'h400, 0, 8'd0, 0, 8'd1));
        applyStimulus(ld(32'h0, 8'd4), ex(1, 32'h5, 32'h0, 1, 8'd4, 0, 8'd1));

        applyStimulus(alu(32'hABC, 8'd6), ex(0, 32'h0, 32'hABC, 1, 8'd6, 0, 8'd1));
        @(posedge clk);
        #3;
        reset = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        checkOutput("async_reset", ex(0, 32'h0, 32'h0, 0, 8'd0, 0, 8'd0));
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(ld(32'h40, 8'd9), ex(1, 32'hDEADBEEF, 32'h40, 1, 8'd9, 0, 8'd0));

        v = st(32'h81, 32'h77777777);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(v, ex(0, 32'h0, 32'h81, 0, 8'd0, 1, (i >= 254) ? 8'd255 : 8'(i + 1)));
        end
        applyStimulus(ld(32'h80, 8'd7), ex(1, 32'h22222222, 32'h80, 1, 8'd7, 0, 8'd255));
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 8'd7},
                      ex(0, 32'h0, 32'h0, 0, 8'd0, 0, 8'd255));

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (scoreboard.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: pending=%0d required=0", scoreboard.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_pipeline_stage4_mem.md
# m_pipeline_stage4_mem

Memory-access stage (stage 4) of the 5-stage MIPS pipeline, including the MEM/WB pipeline register. It accepts the EX/MEM bundle, performs word loads and stores against an internal synchronous data memory, and checks alignment. It registers the result bundle consumed directly by the write-back stage: `mem_to_reg`, `read_data`, `alu_out`, `reg_write`, `write_reg`.

## Interface
- `N`, 32: datapath width in bits.
- `N_REG`, 256: register-file size; register index width is `$clog2(N_REG)`.
- `MEM_WORDS`, 256: data memory depth in words; power of two, at least 2.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `stall` input 1: hold the MEM/WB register and suppress stores.
- `flush` input 1: load a bubble into the MEM/WB register.
- `valid_in` input 1: EX/MEM bundle holds a real instruction.
- `mem_read_in` input 1: load instruction.
- `mem_write_in` input 1: store instruction.
- `mem_to_reg_in` input 1: WB selects memory data.
- `reg_write_in` input 1: instruction writes the register file.
- `alu_out_in` input N: ALU result; also the byte address for memory operations.
- `store_data_in` input N: store data (rt value).
- `write_reg_in` input `$clog2(N_REG)`: destination register.
- `mem_to_reg` output 1: registered, to WB.
- `read_data` output N: registered load data, to WB.
- `alu_out` output N: registered ALU result, to WB.
- `reg_write` output 1: registered, to WB.
- `write_reg` output `$clog2(N_REG)`: registered, to WB.
- `misalign_err` output 1: registered one-cycle pulse marking a misaligned access.
- `err_count` output 8: saturating count of misaligned accesses.

## Operation
- Memory is `MEM_WORDS` x N. Word index = `alu_out_in[$clog2(MEM_WORDS)+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo `MEM_WORDS*4`.
  - Contents are not reset.
- Access is active when `valid_in & (mem_read_in | mem_write_in)`.
  - The access is misaligned when `alu_out_in[1:0] != 0`.
- Store is performed at the edge when all of the following hold: `valid_in`, `mem_write_in`, aligned, `!stall`, `!flush`.
- Load: `read_data` captures `mem[index]` at the same edge that loads the MEM/WB register.
  - With `mem_read_in=0`, `read_data` is loaded with 0.
- When `mem_read_in` and `mem_write_in` are both 1:
  - the store is performed;
  - `read_data` returns the pre-write contents (read-before-write).
- MEM/WB register update priority, evaluated at each edge:
  1. `flush=1`: bubble. All five WB outputs become 0 and `misalign_err` becomes 0. Flush overrides stall.
  2. `stall=1`: all outputs hold, `err_count` holds, no store.
  3. `valid_in=0`: bubble.
  4. Misaligned access:
     - `reg_write`←0 and `mem_to_reg`←0;
     - `alu_out` and `write_reg` are captured;
     - `read_data`←0;
     - `misalign_err`←1;
     - `err_count` increments, saturating at 255;
     - store is suppressed.
  5. Otherwise: all inputs are captured and `misalign_err`←0.
- `misalign_err` is 0 after any non-error load of the register.

## Timing
- Reset (`reset`=0, asynchronous): every output is 0 immediately, including `err_count`. No store occurs while reset is asserted.
- On release, the first capture happens at the first rising edge with `reset`=1.
- Latency: EX/MEM inputs at edge k produce WB outputs valid after edge k. WB combinationally consumes them in the following cycle.
- Store at edge k is visible to a load captured at edge k+1. There is no internal forwarding requirement.
- A stall lasting any number of cycles leaves the outputs bit-identical and performs exactly one store, at the edge after the stall releases.
- Reset asserted mid-stall or mid-store: the outputs clear and any pending store is lost. Memory contents already written are retained.

## Test plan
- Store then load:
  - Cycle 1: store `0xDEADBEEF` to `0x40`.
  - Cycle 2: load `0x40` with `write_reg_in=9`, `reg_write_in=1`, `mem_to_reg_in=1`.
  - Required after edge 2: `read_data=0xDEADBEEF`, `write_reg=9`, `reg_write=1`, `mem_to_reg=1`.
- Misaligned load at `0x42`, `reg_write_in=1`:
  - Required: `reg_write=0`, `read_data=0`, `misalign_err=1` for exactly one cycle, `err_count=1`.
- Stall: register holds a valid ALU op with `alu_out=0x1234`; hold `stall=1` for 3 cycles while presenting a store to `0x80`.
  - Required during the stall: outputs unchanged and `mem[0x80>>2]` unchanged.
  - Required after release: the store is performed once.
- Flush and stall both high with a valid store presented:
  - Required: all WB outputs 0 and no memory write. A subsequent load of that address returns the old value.
- Wrap and saturation, with `MEM_WORDS=256`:
  - Store `0x5` to `0x400`, then load `0x0`. Required: `read_data=0x5`.
  - Issue 300 misaligned accesses. Required: `err_count=255`.
- Async reset asserted between edges while `reg_write=1`:
  - Required: all outputs 0 before the next edge.
  - After release, the first valid instruction is captured normally.
